ctrl_pipe_hazard: RTL and testbench
===================================

// Module: ctrl_pipe_hazard
// PURPOSE
//  Consumer side of the ID-stage control bundle for the 5-stage RV64 pipeline.
//  Pipelines the decoded control signals (ALUOp, Branch, MemRead, MemtoReg,
//  MemWrite, ALUSrc, RegWrite) and register addresses through ID/EX, EX/MEM
//  and MEM/WB. Generates load-use stall, taken-branch flush and EX-operand
//  forwarding selects. Sits between the opcode decoder and the datapath regs.
// PARAMETERS
//  RA_W       5   register address width (x0..x31)
//  FWD_EN     1   1: forwarding selects active; 0: fwd_a/fwd_b forced 2'b00
// PORTS
//  clk            in   1     rising-edge clock
//  reset          in   1     asynchronous, active-high reset
//  id_valid       in   1     ID holds a real instruction; 0 => treat as bubble
//  id_alu_op      in   2     decoder ALUOp
//  id_branch, id_mem_read, id_mem_to_reg, id_mem_write, id_alu_src,
//  id_reg_write   in   1 ea  decoder control bits
//  id_rs1,id_rs2,id_rd in RA_W ID register fields
//  ex_zero        in   1     ALU zero flag of instruction currently in EX
//  ex_alu_op,ex_alu_src out 2/1 ID/EX register contents
//  ex_rs1,ex_rs2,ex_rd  out RA_W ID/EX register contents
//  mem_mem_read,mem_mem_write,mem_reg_write,mem_mem_to_reg out 1 ea EX/MEM
//  mem_rd         out  RA_W  EX/MEM destination
//  wb_reg_write,wb_mem_to_reg out 1 ea; wb_rd out RA_W  MEM/WB contents
//  pc_write       out  1     0 => hold PC this cycle
//  ifid_write     out  1     0 => hold IF/ID this cycle
//  ifid_flush     out  1     1 => IF/ID loads NOP this edge
//  branch_taken   out  1     ex_branch & ex_zero
//  fwd_a, fwd_b   out  2     00 regfile, 10 EX/MEM result, 01 MEM/WB result
// BEHAVIOUR
//  - Reset: all ID/EX, EX/MEM, MEM/WB fields 0 (bubble, rd=0) immediately and
//    held while reset=1; combinational outputs follow: pc_write=1,
//    ifid_write=1, ifid_flush=0, branch_taken=0, fwd_a=fwd_b=00.
//  - Bubble = all control bits 0, ALUOp 00, rs1/rs2/rd 0.
//  - Latency: ID->EX 1 clk, EX->MEM 1 clk, MEM->WB 1 clk; no skipping.
//  - branch_taken (comb) = ex_branch & ex_zero. When 1: ifid_flush=1,
//    ID/EX loads bubble at the edge, pc_write=1, ifid_write=1.
//  - load_use (comb) = ex_mem_read & ex_rd!=0 & (ex_rd==id_rs1 | ex_rd==id_rs2)
//    & id_valid. When 1 and branch_taken=0: pc_write=0, ifid_write=0, ID/EX
//    loads bubble; EX/MEM and MEM/WB advance normally. Stall is exactly 1 clk.
//  - Priority: branch_taken over load_use (flushed instr needs no stall).
//  - id_valid=0: ID/EX loads bubble; no stall raised.
//  - EX/MEM and MEM/WB always advance; never stalled or flushed.
//  - Forwarding (comb, FWD_EN=1), per operand X in {rs1->fwd_a, rs2->fwd_b}:
//    10 if mem_reg_write & mem_rd!=0 & mem_rd==ex_rsX;
//    else 01 if wb_reg_write & wb_rd!=0 & wb_rd==ex_rsX; else 00.
//    EX/MEM wins when both stages match (most recent value).
//  - x0 never forwarded and never causes stall.
//  - Reset asserted mid-stall/flush: state cleared, no pending stall remains.
// TESTING
//  1 reset=1 mid-stream -> all ex_/mem_/wb_ outputs 0, pc_write=1, fwd=00.
//  2 R-type add x5 then sub x6,x5,x7 back-to-back -> second in EX: fwd_a=10;
//    with one unrelated instr between -> fwd_a=01.
//  3 ld x5 then add x6,x5,x1 -> 1 clk pc_write=0, ifid_write=0, ex_* bubble;
//    next clk add in EX with fwd_a=01; no second stall.
//  4 beq in EX with ex_zero=1 and load-use match in ID -> branch_taken=1,
//    ifid_flush=1, pc_write=1, ID/EX bubble; ex_zero=0 -> no flush.
//  5 writes to x0 by ld then use of x0 -> no stall, fwd_a=fwd_b=00.
//  6 both mem_rd and wb_rd == ex_rs2=9 with reg_write=1 -> fwd_b=10;
//    FWD_EN=0 -> fwd_b=00.

Source files
------------

// File: rtl/ctrl_pipe_hazard_if.sv
// ID-stage control bundle and pipeline control outputs for ctrl_pipe_hazard.
// The master side is the decoder/datapath; the slave side is the hazard unit.
interface ctrl_pipe_hazard_if #(
    parameter int RA_W = 5
);
    logic            id_valid;
    logic [1:0]      id_alu_op;
    logic            id_branch;
    logic            id_mem_read;
    logic            id_mem_to_reg;
    logic            id_mem_write;
    logic            id_alu_src;
    logic            id_reg_write;
    logic [RA_W-1:0] id_rs1;
    logic [RA_W-1:0] id_rs2;
    logic [RA_W-1:0] id_rd;
    logic            ex_zero;

    logic [1:0]      ex_alu_op;
    logic            ex_alu_src;
    logic [RA_W-1:0] ex_rs1;
    logic [RA_W-1:0] ex_rs2;
    logic [RA_W-1:0] ex_rd;
    logic            mem_mem_read;
    logic            mem_mem_write;
    logic            mem_reg_write;
    logic            mem_mem_to_reg;
    logic [RA_W-1:0] mem_rd;
    logic            wb_reg_write;
    logic            wb_mem_to_reg;
    logic [RA_W-1:0] wb_rd;
    logic            pc_write;
    logic            ifid_write;
    logic            ifid_flush;
    logic            branch_taken;
    logic [1:0]      fwd_a;
    logic [1:0]      fwd_b;

    modport master (
        output id_valid, id_alu_op, id_branch, id_mem_read, id_mem_to_reg,
               id_mem_write, id_alu_src, id_reg_write, id_rs1, id_rs2,
               id_rd, ex_zero,
        input  ex_alu_op, ex_alu_src, ex_rs1, ex_rs2, ex_rd,
               mem_mem_read, mem_mem_write, mem_reg_write, mem_mem_to_reg,
               mem_rd, wb_reg_write, wb_mem_to_reg, wb_rd, pc_write,
               ifid_write, ifid_flush, branch_taken, fwd_a, fwd_b
    );

    modport slave (
        input  id_valid, id_alu_op, id_branch, id_mem_read, id_mem_to_reg,
               id_mem_write, id_alu_src, id_reg_write, id_rs1, id_rs2,
               id_rd, ex_zero,
        output ex_alu_op, ex_alu_src, ex_rs1, ex_rs2, ex_rd,
               mem_mem_read, mem_mem_write, mem_reg_write, mem_mem_to_reg,
               mem_rd, wb_reg_write, wb_mem_to_reg, wb_rd, pc_write,
               ifid_write, ifid_flush, branch_taken, fwd_a, fwd_b
    );
endinterface

// File: rtl/ctrl_pipe_hazard.sv
// Control pipeline ID/EX -> EX/MEM -> MEM/WB with load-use stall,
// taken-branch flush and EX operand forwarding selects.
module ctrl_pipe_hazard #(
    parameter int RA_W   = 5,
    parameter bit FWD_EN = 1'b1
) (
    input logic              clk,
    input logic              reset,
    ctrl_pipe_hazard_if.slave bus
);
    typedef struct packed {
        logic [1:0]      alu_op;
        logic            branch;
        logic            mem_read;
        logic            mem_to_reg;
        logic            mem_write;
        logic            alu_src;
        logic            reg_write;
        logic [RA_W-1:0] rs1;
        logic [RA_W-1:0] rs2;
        logic [RA_W-1:0] rd;
    } idex_t;

    idex_t           r_ex;
    idex_t           w_ex_nxt;
    logic            r_mem_mem_read;
    logic            r_mem_mem_write;
    logic            r_mem_reg_write;
    logic            r_mem_mem_to_reg;
    logic [RA_W-1:0] r_mem_rd;
    logic            r_wb_reg_write;
    logic            r_wb_mem_to_reg;
    logic [RA_W-1:0] r_wb_rd;
    logic            w_branch_taken;
    logic            w_load_use;
    logic            w_stall;
    logic [1:0]      w_fwd_a;
    logic [1:0]      w_fwd_b;

    function automatic logic [1:0] fwd_sel(input logic [RA_W-1:0] rs);
        logic [1:0] sel;
        sel = 2'b00;
        if (r_mem_reg_write && r_mem_rd != '0 && r_mem_rd == rs)
            sel = 2'b10;
        else if (r_wb_reg_write && r_wb_rd != '0 && r_wb_rd == rs)
            sel = 2'b01;
        return sel;
    endfunction

    // A taken branch kills the ID instruction, so its load-use stall is moot.
    always_comb begin
        w_branch_taken = r_ex.branch & bus.ex_zero;
        w_load_use     = r_ex.mem_read && r_ex.rd != '0 && bus.id_valid &&
                         (r_ex.rd == bus.id_rs1 || r_ex.rd == bus.id_rs2);
        w_stall        = w_load_use & ~w_branch_taken;
        w_ex_nxt       = '0;
        if (bus.id_valid && !w_branch_taken && !w_load_use) begin
            w_ex_nxt.alu_op     = bus.id_alu_op;
            w_ex_nxt.branch     = bus.id_branch;
            w_ex_nxt.mem_read   = bus.id_mem_read;
            w_ex_nxt.mem_to_reg = bus.id_mem_to_reg;
            w_ex_nxt.mem_write  = bus.id_mem_write;
            w_ex_nxt.alu_src    = bus.id_alu_src;
            w_ex_nxt.reg_write  = bus.id_reg_write;
            w_ex_nxt.rs1        = bus.id_rs1;
            w_ex_nxt.rs2        = bus.id_rs2;
            w_ex_nxt.rd         = bus.id_rd;
        end
        w_fwd_a = FWD_EN ? fwd_sel(r_ex.rs1) : 2'b00;
        w_fwd_b = FWD_EN ? fwd_sel(r_ex.rs2) : 2'b00;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ex             <= '0;
            r_mem_mem_read   <= 1'b0;
            r_mem_mem_write  <= 1'b0;
            r_mem_reg_write  <= 1'b0;
            r_mem_mem_to_reg <= 1'b0;
            r_mem_rd         <= '0;
            r_wb_reg_write   <= 1'b0;
            r_wb_mem_to_reg  <= 1'b0;
            r_wb_rd          <= '0;
        end else begin
            r_ex             <= w_ex_nxt;
            r_mem_mem_read   <= r_ex.mem_read;
            r_mem_mem_write  <= r_ex.mem_write;
            r_mem_reg_write  <= r_ex.reg_write;
            r_mem_mem_to_reg <= r_ex.mem_to_reg;
            r_mem_rd         <= r_ex.rd;
            r_wb_reg_write   <= r_mem_reg_write;
            r_wb_mem_to_reg  <= r_mem_mem_to_reg;
            r_wb_rd          <= r_mem_rd;
        end
    end

    assign bus.ex_alu_op      = r_ex.alu_op;
    assign bus.ex_alu_src     = r_ex.alu_src;
    assign bus.ex_rs1         = r_ex.rs1;
    assign bus.ex_rs2         = r_ex.rs2;
    assign bus.ex_rd          = r_ex.rd;
    assign bus.mem_mem_read   = r_mem_mem_read;
    assign bus.mem_mem_write  = r_mem_mem_write;
    assign bus.mem_reg_write  = r_mem_reg_write;
    assign bus.mem_mem_to_reg = r_mem_mem_to_reg;
    assign bus.mem_rd         = r_mem_rd;
    assign bus.wb_reg_write   = r_wb_reg_write;
    assign bus.wb_mem_to_reg  = r_wb_mem_to_reg;
    assign bus.wb_rd          = r_wb_rd;
    assign bus.pc_write       = ~w_stall;
    assign bus.ifid_write     = ~w_stall;
    assign bus.ifid_flush     = w_branch_taken;
    assign bus.branch_taken   = w_branch_taken;
    assign bus.fwd_a          = w_fwd_a;
    assign bus.fwd_b          = w_fwd_b;
endmodule

// File: tb/tb_ctrl_pipe_hazard.sv
// Directed bench for ctrl_pipe_hazard: forwarding, load-use stall,
// branch flush, x0 handling, reset mid-stall and FWD_EN=0 variant.
module tb_ctrl_pipe_hazard;
    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    ctrl_pipe_hazard_if #(.RA_W(5)) u_if0 ();
    ctrl_pipe_hazard_if #(.RA_W(5)) u_if1 ();

    ctrl_pipe_hazard #(.RA_W(5), .FWD_EN(1'b1)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (u_if0.slave)
    );

    ctrl_pipe_hazard #(.RA_W(5), .FWD_EN(1'b0)) u_dut_nofwd (
        .clk   (clk),
        .reset (reset),
        .bus   (u_if1.slave)
    );

    assign u_if1.id_valid      = u_if0.id_valid;
    assign u_if1.id_alu_op     = u_if0.id_alu_op;
    assign u_if1.id_branch     = u_if0.id_branch;
    assign u_if1.id_mem_read   = u_if0.id_mem_read;
    assign u_if1.id_mem_to_reg = u_if0.id_mem_to_reg;
    assign u_if1.id_mem_write  = u_if0.id_mem_write;
    assign u_if1.id_alu_src    = u_if0.id_alu_src;
    assign u_if1.id_reg_write  = u_if0.id_reg_write;
    assign u_if1.id_rs1        = u_if0.id_rs1;
    assign u_if1.id_rs2        = u_if0.id_rs2;
    assign u_if1.id_rd         = u_if0.id_rd;
    assign u_if1.ex_zero       = u_if0.ex_zero;

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_id(input logic v, input logic [1:0] op,
                          input logic br, input logic mr, input logic m2r,
                          input logic mw, input logic as, input logic rw,
                          input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [4:0] rd);
        u_if0.id_valid      = v;
        u_if0.id_alu_op     = op;
        u_if0.id_branch     = br;
        u_if0.id_mem_read   = mr;
        u_if0.id_mem_to_reg = m2r;
        u_if0.id_mem_write  = mw;
        u_if0.id_alu_src    = as;
        u_if0.id_reg_write  = rw;
        u_if0.id_rs1        = rs1;
        u_if0.id_rs2        = rs2;
        u_if0.id_rd         = rd;
    endtask

    task automatic rtype(input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2);
        set_id(1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
               rs1, rs2, rd);
    endtask

    task automatic ld(input logic [4:0] rd, input logic [4:0] rs1);
        set_id(1'b1, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1,
               rs1, 5'd0, rd);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        u_if0.ex_zero = 1'b0;
        set_id(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
               5'd0, 5'd0, 5'd0);
        tick();
        tick();
        chk("rst_ex_rd", 8'(u_if0.ex_rd), 8'd0);
        chk("rst_ex_alu_op", 8'(u_if0.ex_alu_op), 8'd0);
        chk("rst_mem_rd", 8'(u_if0.mem_rd), 8'd0);
        chk("rst_wb_rw", 8'(u_if0.wb_reg_write), 8'd0);
        chk("rst_pc_write", 8'(u_if0.pc_write), 8'd1);
        chk("rst_ifid_write", 8'(u_if0.ifid_write), 8'd1);
        chk("rst_flush", 8'(u_if0.ifid_flush), 8'd0);
        chk("rst_fwd_a", 8'(u_if0.fwd_a), 8'd0);
        reset = 1'b0;

        // back-to-back dependency: EX/MEM forward
        rtype(5'd5, 5'd1, 5'd2);
        tick();
        rtype(5'd6, 5'd5, 5'd7);
        #1;
        chk("b2b_no_stall", 8'(u_if0.pc_write), 8'd1);
        tick();
        chk("b2b_ex_rs1", 8'(u_if0.ex_rs1), 8'd5);
        chk("b2b_fwd_a", 8'(u_if0.fwd_a), 8'b10);
        chk("b2b_fwd_b", 8'(u_if0.fwd_b), 8'b00);

        // one unrelated instruction between: MEM/WB forward
        rtype(5'd10, 5'd1, 5'd2);
        tick();
        rtype(5'd11, 5'd1, 5'd2);
        tick();
        rtype(5'd12, 5'd10, 5'd3);
        tick();
        chk("gap_mem_rd", 8'(u_if0.mem_rd), 8'd11);
        chk("gap_wb_rd", 8'(u_if0.wb_rd), 8'd10);
        chk("gap_fwd_a", 8'(u_if0.fwd_a), 8'b01);

        // load-use: exactly one stall cycle
        ld(5'd5, 5'd1);
        tick();
        rtype(5'd6, 5'd5, 5'd1);
        #1;
        chk("lu_pc_write", 8'(u_if0.pc_write), 8'd0);
        chk("lu_ifid_write", 8'(u_if0.ifid_write), 8'd0);
        chk("lu_flush", 8'(u_if0.ifid_flush), 8'd0);
        tick();
        chk("lu_ex_bubble_rd", 8'(u_if0.ex_rd), 8'd0);
        chk("lu_ex_bubble_op", 8'(u_if0.ex_alu_src), 8'd0);
        chk("lu_mem_rd", 8'(u_if0.mem_rd), 8'd5);
        chk("lu_mem_read", 8'(u_if0.mem_mem_read), 8'd1);
        chk("lu_no_2nd_stall", 8'(u_if0.pc_write), 8'd1);
        tick();
        chk("lu_ex_rd", 8'(u_if0.ex_rd), 8'd6);
        chk("lu_wb_m2r", 8'(u_if0.wb_mem_to_reg), 8'd1);
        chk("lu_fwd_a", 8'(u_if0.fwd_a), 8'b01);

        // branch in EX that is also a load matching ID: branch wins
        set_id(1'b1, 2'b01, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
               5'd1, 5'd2, 5'd4);
        tick();
        rtype(5'd13, 5'd4, 5'd3);
        u_if0.ex_zero = 1'b1;
        #1;
        chk("br_taken", 8'(u_if0.branch_taken), 8'd1);
        chk("br_flush", 8'(u_if0.ifid_flush), 8'd1);
        chk("br_pc_write", 8'(u_if0.pc_write), 8'd1);
        chk("br_ifid_write", 8'(u_if0.ifid_write), 8'd1);
        tick();
        u_if0.ex_zero = 1'b0;
        chk("br_ex_bubble", 8'(u_if0.ex_rd), 8'd0);

        // branch not taken
        set_id(1'b1, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
               5'd1, 5'd2, 5'd0);
        tick();
        rtype(5'd13, 5'd1, 5'd2);
        #1;
        chk("nbr_taken", 8'(u_if0.branch_taken), 8'd0);
        chk("nbr_flush", 8'(u_if0.ifid_flush), 8'd0);
        tick();
        chk("nbr_ex_rd", 8'(u_if0.ex_rd), 8'd13);

        // load to x0 then use of x0
        ld(5'd0, 5'd1);
        tick();
        rtype(5'd14, 5'd0, 5'd0);
        #1;
        chk("x0_no_stall", 8'(u_if0.pc_write), 8'd1);
        tick();
        chk("x0_ex_rd", 8'(u_if0.ex_rd), 8'd14);
        chk("x0_fwd_a", 8'(u_if0.fwd_a), 8'b00);
        chk("x0_fwd_b", 8'(u_if0.fwd_b), 8'b00);

        // both stages write x9: EX/MEM wins; FWD_EN=0 forces 00
        rtype(5'd9, 5'd1, 5'd2);
        tick();
        rtype(5'd9, 5'd1, 5'd2);
        tick();
        rtype(5'd20, 5'd1, 5'd9);
        tick();
        chk("dbl_fwd_b", 8'(u_if0.fwd_b), 8'b10);
        chk("nofwd_fwd_b", 8'(u_if1.fwd_b), 8'b00);

        // id_valid=0 gives a bubble
        set_id(1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
               5'd1, 5'd2, 5'd15);
        tick();
        chk("inv_ex_rd", 8'(u_if0.ex_rd), 8'd0);

        // reset asserted mid-stall
        rtype(5'd21, 5'd1, 5'd2);
        tick();
        ld(5'd5, 5'd1);
        tick();
        rtype(5'd6, 5'd5, 5'd1);
        #1;
        chk("mrst_stalled", 8'(u_if0.pc_write), 8'd0);
        reset = 1'b1;
        #1;
        chk("mrst_ex_rd", 8'(u_if0.ex_rd), 8'd0);
        chk("mrst_mem_rd", 8'(u_if0.mem_rd), 8'd0);
        chk("mrst_wb_rd", 8'(u_if0.wb_rd), 8'd0);
        chk("mrst_pc_write", 8'(u_if0.pc_write), 8'd1);
        chk("mrst_fwd_a", 8'(u_if0.fwd_a), 8'd0);
        reset = 1'b0;
        tick();
        chk("mrst_ex_after", 8'(u_if0.ex_rd), 8'd6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
